// File: rtl/aes_pkg.sv
// ----------------------------------------------------------------------------
// aes_pkg
// Shared widths, types and small helpers for the AES datapath blocks.
//   aes_block_t : one 128-bit AES block
//   aes_word_t  : one 32-bit bus word
//   aes_widx_t  : index of a word within a block (0 = most significant)
// ----------------------------------------------------------------------------
package aes_pkg;

    localparam int AES_BLOCK_W       = 128;
    localparam int AES_WORD_W        = 32;
    localparam int AES_WORDS_PER_BLK = 4;

    typedef logic [AES_BLOCK_W-1:0]               aes_block_t;
    typedef logic [AES_WORD_W-1:0]                aes_word_t;
    typedef logic [$clog2(AES_WORDS_PER_BLK)-1:0] aes_widx_t;

    // Word idx of a block, most significant word first.
    function automatic aes_word_t aes_word_sel(input aes_block_t blk, input aes_widx_t idx);
        aes_word_t w;
        case (idx)
            2'd0:    w = blk[127:96];
            2'd1:    w = blk[95:64];
            2'd2:    w = blk[63:32];
            default: w = blk[31:0];
        endcase
        return w;
    endfunction

    // Reverse the byte order of a word for little-endian consumers.
    function automatic aes_word_t aes_byte_swap(input aes_word_t w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_blk_fifo.sv
// ----------------------------------------------------------------------------
// aes_blk_fifo
// Generic DEPTH x 128-bit register FIFO. Usable on either side of the AES core.
// A push while full is accepted only if a pop happens on the same edge.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   push         : write push_data at the tail (ignored when full and not popping)
//   push_data    : block to write
//   pop          : release the head (ignored when empty)
//   head         : block at the head (don't-care when empty)
//   full, empty  : occupancy flags
//   level        : number of blocks held
// ----------------------------------------------------------------------------
module aes_blk_fifo
    import aes_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [127:0]     push_data,
    input  logic             pop,
    output logic [127:0]     head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);

    aes_block_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rd_ptr];
    assign level   = count;

    // NOTE: the storage array has no reset; nothing reads a slot before it has
    // been written, because the empty flag gates every consumer of head.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/aes_out_serializer.sv
// ----------------------------------------------------------------------------
// aes_out_serializer
// Buffers 128-bit AES results and streams them out as 32-bit words,
// most significant word first, over a valid/ready handshake.
// Optional build macro AES_OUT_BYTESWAP_EN: byte-reverse each output word.
// Ports:
//   AES_clk, AES_rst_n  : clock, asynchronous active-low reset
//   AES_data_out_valid  : single-cycle strobe from the core
//   AES_data_out        : result block, sampled only on the strobe edge
//   out_data/out_valid  : current word and its valid (zero when empty)
//   out_ready           : consumer accepts the word
//   out_last            : current word is the last of its block
//   ovf_clr             : synchronous clear of ovf
//   ovf                 : sticky, a block was dropped because the buffer was full
//   level               : blocks held, including one partially sent
// ----------------------------------------------------------------------------
module aes_out_serializer
    import aes_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             AES_clk,
    input  logic             AES_rst_n,
    input  logic             AES_data_out_valid,
    input  logic [127:0]     AES_data_out,
    output logic [31:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    input  logic             ovf_clr,
    output logic             ovf,
    output logic [CNT_W-1:0] level
);

    localparam aes_widx_t LAST_WIDX = aes_widx_t'(AES_WORDS_PER_BLK - 1);

    aes_block_t head;
    logic       full;
    logic       empty;
    aes_widx_t  widx;
    logic       xfer;
    logic       pop;
    logic       drop;
    aes_word_t  sel_word;
    aes_word_t  out_word;

    assign out_valid = !empty;
    assign xfer      = out_valid && out_ready;
    assign pop       = xfer && (widx == LAST_WIDX);
    // A full buffer still takes the block when its head leaves on the same edge.
    assign drop      = AES_data_out_valid && full && !pop;

    aes_blk_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (AES_clk),
        .rst_n     (AES_rst_n),
        .push      (AES_data_out_valid),
        .push_data (AES_data_out),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            widx <= '0;
            ovf  <= 1'b0;
        end else begin
            // Index wraps 3 -> 0 exactly when the head is popped.
            if (xfer) widx <= widx + 1'b1;
            // A new drop outranks a clear on the same edge.
            if (drop)         ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
        end
    end

    assign sel_word = aes_word_sel(head, widx);

`ifdef AES_OUT_BYTESWAP_EN
    assign out_word = aes_byte_swap(sel_word);
`else
    assign out_word = sel_word;
`endif

    assign out_data = out_valid ? out_word : '0;
    assign out_last = out_valid && (widx == LAST_WIDX);

endmodule

// File: tb/tb_aes_out_serializer.sv
// ----------------------------------------------------------------------------
// tb_aes_out_serializer
// Directed bench for aes_out_serializer (DEPTH=2). Expected words are queued
// when a block is issued; a monitor pops and compares on every transfer.
// ----------------------------------------------------------------------------
module tb_aes_out_serializer;

    localparam int DEPTH = 2;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             AES_clk = 1'b0;
    logic             AES_rst_n;
    logic             AES_data_out_valid;
    logic [127:0]     AES_data_out;
    logic [31:0]      out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             ovf_clr;
    logic             ovf;
    logic [CNT_W-1:0] level;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [127:0] B1 = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] B2 = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    localparam logic [127:0] B3 = 128'h11111111_22222222_33333333_44444444;
    localparam logic [127:0] B4 = 128'ha5a5a5a5_5a5a5a5a_0f0f0f0f_f0f0f0f0;
    localparam logic [127:0] B5 = 128'h01020304_05060708_090a0b0c_0d0e0f10;

    aes_out_serializer #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .AES_clk            (AES_clk),
        .AES_rst_n          (AES_rst_n),
        .AES_data_out_valid (AES_data_out_valid),
        .AES_data_out       (AES_data_out),
        .out_data           (out_data),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_last           (out_last),
        .ovf_clr            (ovf_clr),
        .ovf                (ovf),
        .level              (level)
    );

    always #5 AES_clk = ~AES_clk;

    // Expected word i of a block, as the consumer should see it.
    function automatic logic [31:0] exp_word(input logic [127:0] blk, input int i);
        logic [31:0] w;
        w = blk[127 - 32*i -: 32];
`ifdef AES_OUT_BYTESWAP_EN
        w = {w[7:0], w[15:8], w[23:16], w[31:24]};
`endif
        return w;
    endfunction

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Present a block for one edge; queue its words if it should be kept.
    // Entered and left at 1 time unit after a rising edge.
    task automatic capture(input logic [127:0] blk, input bit keep);
        exp_t e;
        AES_data_out_valid = 1'b1;
        AES_data_out       = blk;
        if (keep) begin
            for (int i = 0; i < 4; i++) begin
                e.data = exp_word(blk, i);
                e.last = (i == 3);
                exp_q.push_back(e);
            end
        end
        @(posedge AES_clk);
        #1;
        AES_data_out_valid = 1'b0;
        AES_data_out       = '0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!(exp_q.size() == 0 && level == '0) && n < 200) begin
            @(posedge AES_clk);
            #1;
            n++;
        end
        check(name, {63'd0, (exp_q.size() == 0 && level == '0)}, 64'd1);
    endtask

    // Monitor: every accepted word must match the head of the expectation queue.
    always @(negedge AES_clk) begin
        if (AES_rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %h, expected no word", out_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("word", {31'd0, out_last, out_data}, {31'd0, e.last, e.data});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        AES_rst_n          = 1'b0;
        AES_data_out_valid = 1'b0;
        AES_data_out       = '0;
        out_ready          = 1'b0;
        ovf_clr            = 1'b0;
        #1;
        check("rst_outputs", {29'd0, out_valid, out_last, ovf, out_data}, 64'd0);
        check("rst_level", 64'(level), 64'd0);
        repeat (2) @(posedge AES_clk);
        #3;
        AES_rst_n = 1'b1;
        @(posedge AES_clk);
        #1;

        // 1. single block, consumer always ready
        out_ready = 1'b1;
        capture(B1, 1'b1);
        check("t1_level", 64'(level), 64'd1);
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_word0", 64'(out_data), 64'(exp_word(B1, 0)));
        wait_idle("t1_drain");
        check("t1_idle_out", {31'd0, out_valid, out_data}, 64'd0);

        // 2. back-pressure while word 1 is presented
        capture(B1, 1'b1);
        @(posedge AES_clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("t2_stall", {31'd0, out_valid, out_data}, {31'd0, 1'b1, exp_word(B1, 1)});
            @(posedge AES_clk);
            #1;
        end
        out_ready = 1'b1;
        wait_idle("t2_drain");

        // 3. overflow: third block dropped, then clear
        out_ready = 1'b0;
        capture(B1, 1'b1);
        capture(B2, 1'b1);
        check("t3_ovf_before", 64'(ovf), 64'd0);
        capture(B3, 1'b0);
        check("t3_level", 64'(level), 64'd2);
        check("t3_ovf_set", 64'(ovf), 64'd1);
        ovf_clr = 1'b1;
        @(posedge AES_clk);
        #1;
        ovf_clr = 1'b0;
        check("t3_ovf_clr", 64'(ovf), 64'd0);
        // a drop coinciding with a clear leaves ovf set
        ovf_clr = 1'b1;
        capture(B4, 1'b0);
        ovf_clr = 1'b0;
        check("t3_set_wins", 64'(ovf), 64'd1);
        ovf_clr = 1'b1;
        @(posedge AES_clk);
        #1;
        ovf_clr = 1'b0;
        out_ready = 1'b1;
        wait_idle("t3_drain");

        // 4. full, capture on the same edge as the head's last word
        out_ready = 1'b0;
        capture(B1, 1'b1);
        capture(B2, 1'b1);
        out_ready = 1'b1;
        repeat (3) begin
            @(posedge AES_clk);
            #1;
        end
        check("t4_last_shown", {31'd0, out_last, out_data}, {31'd0, 1'b1, exp_word(B1, 3)});
        capture(B5, 1'b1);
        check("t4_level", 64'(level), 64'd2);
        check("t4_ovf", 64'(ovf), 64'd0);
        wait_idle("t4_drain");

        // 5. reset in the middle of a block
        capture(B2, 1'b1);
        repeat (2) begin
            @(posedge AES_clk);
            #1;
        end
        AES_rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("t5_rst_out", {29'd0, out_valid, out_last, ovf, out_data}, 64'd0);
        check("t5_rst_level", 64'(level), 64'd0);
        @(posedge AES_clk);
        #3;
        AES_rst_n = 1'b1;
        repeat (3) begin
            @(posedge AES_clk);
            #1;
        end
        check("t5_post_rst", {31'd0, out_valid, out_data}, 64'd0);
        capture(B3, 1'b1);
        check("t5_new_word0", 64'(out_data), 64'(exp_word(B3, 0)));
        wait_idle("t5_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
